// File: rtl/result_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : result_sched_if
// Description : Sample input, converter handshake and result bundle for
//               result_sched. The slave view belongs to the scheduler, the
//               master view to whatever drives and observes it.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_sched_if;
  // sample input side
  logic        enable;
  logic        clr;
  logic        speeden;
  logic [15:0] speedX;
  logic [15:0] speedY;
  // rectangular-to-polar converter handshake
  logic        cordic_start;
  logic [15:0] cordic_x;
  logic [15:0] cordic_y;
  logic        cordic_busy;
  logic [15:0] cordic_mod;
  logic [15:0] cordic_angle;
  // results and status
  logic [15:0] mod;
  logic [15:0] angle;
  logic        valid;
  logic [15:0] overrun_cnt;
  logic        timeout;
  logic [4:0]  fifo_level;

  modport slave (
    input  enable, clr, speeden, speedX, speedY,
    input  cordic_busy, cordic_mod, cordic_angle,
    output cordic_start, cordic_x, cordic_y,
    output mod, angle, valid, overrun_cnt, timeout, fifo_level
  );

  modport master (
    output enable, clr, speeden, speedX, speedY,
    output cordic_busy, cordic_mod, cordic_angle,
    input  cordic_start, cordic_x, cordic_y,
    input  mod, angle, valid, overrun_cnt, timeout, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/result_sched.sv
`default_nettype none
// ============================================================================
// Module      : result_sched
// Description : Queues speed samples and feeds them one at a time to a
//               rectangular-to-polar converter, supervising its ack and run
//               time and publishing the modulus/angle of each finished job.
// Revision    : 1.0 - initial release
// ============================================================================
module result_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_WAIT    = 8,
  parameter int RUN_TIMEOUT = 255
) (
  input  wire logic     clock,
  input  wire logic     reset_n,
  result_sched_if.slave bus
);

  localparam int c_AW      = $clog2(FIFO_DEPTH);
  localparam int c_PW      = c_AW + 1;
  localparam int c_CNT_MAX = (RUN_TIMEOUT > ACK_WAIT) ? RUN_TIMEOUT : ACK_WAIT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_ACK_LAST = c_CNT_W'(ACK_WAIT - 1);
  localparam logic [c_CNT_W-1:0] c_RUN_LAST = c_CNT_W'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    CAPTURE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_start;
  logic [15:0]          r_x;
  logic [15:0]          r_y;
  logic [15:0]          r_mod;
  logic [15:0]          r_angle;
  logic                 r_valid;
  logic                 r_timeout;
  logic [15:0]          r_ovr;

  logic [31:0]          r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]      r_wr_ptr;
  logic [c_PW-1:0]      r_rd_ptr;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_PW-1:0]      w_diff;
  logic [31:0]          w_head;

  // The extra pointer bit tells a full queue (MSBs differ) from an empty one.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_diff     = r_wr_ptr - r_rd_ptr;
  assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];

  // The sequencer only takes a sample while idle; a pop in the same cycle
  // frees a slot, so a push into a full queue is then still accepted.
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_push_req = bus.speeden & bus.enable;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.speedX, bus.speedY};
    end
  end

  // Queue pointers and the saturating dropped-sample counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovr    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      if (bus.clr) begin
        r_ovr <= '0;
      end else if (w_drop && (r_ovr != 16'hFFFF)) begin
        r_ovr <= r_ovr + 16'd1;
      end
    end
  end

  // Job sequencer: launch the head sample, wait for ack, supervise the run,
  // then capture the result; a missing ack or an endless run sets timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_mod     <= '0;
      r_angle   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_x     <= w_head[31:16];
            r_y     <= w_head[15:0];
            r_start <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.cordic_busy) begin
            r_cnt   <= '0;
            r_state <= RUN;
          end else if (r_cnt == c_ACK_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        RUN: begin
          if (!bus.cordic_busy) begin
            r_state <= CAPTURE;
          end else if (r_cnt == c_RUN_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        CAPTURE: begin
          r_mod   <= bus.cordic_mod;
          r_angle <= bus.cordic_angle;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // clear wins over a timeout raised in the same cycle
      if (bus.clr) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign bus.cordic_start = r_start;
  assign bus.cordic_x     = r_x;
  assign bus.cordic_y     = r_y;
  assign bus.mod          = r_mod;
  assign bus.angle        = r_angle;
  assign bus.valid        = r_valid;
  assign bus.overrun_cnt  = r_ovr;
  assign bus.timeout      = r_timeout;
  assign bus.fifo_level   = 5'(w_diff);

endmodule
`default_nettype wire

// File: tb/tb_result_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_sched
// Description : Self-checking bench for result_sched with a behavioural
//               converter and a queue-based expectation of accepted samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_sched;

  localparam int FIFO_DEPTH  = 4;
  localparam int ACK_WAIT    = 8;
  localparam int RUN_TIMEOUT = 255;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  result_sched_if bus ();

  result_sched #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACK_WAIT    (ACK_WAIT),
    .RUN_TIMEOUT (RUN_TIMEOUT)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial forever #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          conv_mode = 0;   // 0 normal, 1 never acks, 2 busy stuck high
  int          conv_lat  = 20;
  int          exp_ovr   = 0;
  int          n_b;
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  logic [31:0] last_res = '0;

  function automatic logic [15:0] conv_mod(input logic [15:0] x, input logic [15:0] y);
    return x + y;
  endfunction

  function automatic logic [15:0] conv_ang(input logic [15:0] x, input logic [15:0] y);
    return x ^ y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_start"}, 32'(bus.cordic_start), 0);
    check({pfx, "_cx"},    32'(bus.cordic_x),     0);
    check({pfx, "_cy"},    32'(bus.cordic_y),     0);
    check({pfx, "_mod"},   32'(bus.mod),          0);
    check({pfx, "_angle"}, 32'(bus.angle),        0);
    check({pfx, "_valid"}, 32'(bus.valid),        0);
    check({pfx, "_ovr"},   32'(bus.overrun_cnt),  0);
    check({pfx, "_to"},    32'(bus.timeout),      0);
    check({pfx, "_level"}, 32'(bus.fifo_level),   0);
  endtask

  // Back-to-back samples into an idle scheduler: the first is taken at once,
  // so the burst fits one job in flight plus FIFO_DEPTH queued; the rest drop.
  task automatic burst(input int n, input int clr_at);
    logic [15:0] x, y;
    @(posedge clock); #1;
    for (int i = 0; i < n; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      bus.speeden = 1'b1;
      bus.speedX  = x;
      bus.speedY  = y;
      bus.clr     = (i == clr_at);
      if (bus.enable) begin
        if (i <= FIFO_DEPTH) exp_q.push_back({conv_mod(x, y), conv_ang(x, y)});
        else exp_ovr++;
      end
      if (i == clr_at) exp_ovr = 0;
      @(posedge clock); #1;
    end
    bus.speeden = 1'b0;
    bus.clr     = 1'b0;
  endtask

  task automatic clr_pulse();
    @(posedge clock); #1;
    bus.clr = 1'b1;
    @(posedge clock); #1;
    bus.clr = 1'b0;
    exp_ovr = 0;
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((obs_q.size() < exp_q.size() || bus.fifo_level != 5'd0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    check("drain_done", 32'(k < budget), 1);
    check("valid_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("result", obs_q[i], exp_q[i]);
    end
    if (exp_q.size() > 0) last_res = exp_q[exp_q.size() - 1];
    obs_q.delete();
    exp_q.delete();
  endtask

  // Converter: acks a start one cycle later and stays busy conv_lat cycles,
  // presenting its result as busy falls.
  initial begin : conv_model
    logic [15:0] jx, jy;
    bus.cordic_busy  = 1'b0;
    bus.cordic_mod   = '0;
    bus.cordic_angle = '0;
    forever begin
      @(negedge clock);
      if (bus.cordic_start === 1'b1 && conv_mode != 1) begin
        jx = bus.cordic_x;
        jy = bus.cordic_y;
        @(posedge clock); #1;
        bus.cordic_busy = 1'b1;
        if (conv_mode == 2) begin
          while (conv_mode == 2) @(posedge clock);
          #1;
        end else begin
          repeat (conv_lat) @(posedge clock);
          #1;
          bus.cordic_mod   = conv_mod(jx, jy);
          bus.cordic_angle = conv_ang(jx, jy);
        end
        bus.cordic_busy = 1'b0;
      end
    end
  end

  // Result monitor
  initial forever begin
    @(negedge clock);
    if (bus.valid === 1'b1) obs_q.push_back({bus.mod, bus.angle});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable  = 1'b1;
    bus.clr     = 1'b0;
    bus.speeden = 1'b0;
    bus.speedX  = '0;
    bus.speedY  = '0;

    // reset state
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    // single sample: start two cycles after the strobe, one result
    conv_lat = 20;
    @(posedge clock); #1;
    bus.speeden = 1'b1;
    bus.speedX  = 16'h0400;
    bus.speedY  = 16'h0000;
    exp_q.push_back({conv_mod(16'h0400, 16'h0000), conv_ang(16'h0400, 16'h0000)});
    @(negedge clock);
    check("lat_c0_start", 32'(bus.cordic_start), 0);
    @(posedge clock); #1;
    bus.speeden = 1'b0;
    @(negedge clock);
    check("lat_c1_start", 32'(bus.cordic_start), 0);
    check("lat_c1_level", 32'(bus.fifo_level), 1);
    @(negedge clock);
    check("lat_c2_start", 32'(bus.cordic_start), 1);
    check("lat_c2_x", 32'(bus.cordic_x), 32'h0400);
    @(negedge clock);
    check("lat_c3_start", 32'(bus.cordic_start), 0);
    drain(200);
    check("single_mod", 32'(bus.mod), 32'(last_res[31:16]));

    // burst of six against a slow converter
    conv_lat = 40;
    burst(6, -1);
    @(negedge clock); @(negedge clock);
    check("burst_level", 32'(bus.fifo_level), FIFO_DEPTH);
    check("burst_ovr", 32'(bus.overrun_cnt), 32'(exp_ovr));
    drain(600);

    // randomized bursts
    for (int r = 0; r < 6; r++) begin
      n_b      = $urandom_range(1, FIFO_DEPTH + 3);
      conv_lat = $urandom_range(12, 30);
      burst(n_b, -1);
      @(negedge clock); @(negedge clock);
      check("rnd_level", 32'(bus.fifo_level), ((n_b > FIFO_DEPTH + 1) ? FIFO_DEPTH + 1 : n_b) - 1);
      check("rnd_ovr", 32'(bus.overrun_cnt), 32'(exp_ovr));
      drain(800);
    end

    // ack timeout: ACK_WAIT cycles in WAIT_ACK, job discarded
    conv_mode = 1;
    @(posedge clock); #1;
    bus.speeden = 1'b1;
    bus.speedX  = 16'($urandom);
    bus.speedY  = 16'($urandom);
    @(posedge clock); #1;
    bus.speeden = 1'b0;
    repeat (ACK_WAIT + 2) @(negedge clock);
    check("ack_to_before", 32'(bus.timeout), 0);
    @(negedge clock);
    check("ack_to_set", 32'(bus.timeout), 1);
    repeat (5) @(negedge clock);
    check("ack_no_valid", 32'(obs_q.size()), 0);
    conv_mode = 0;
    conv_lat  = 15;
    burst(1, -1);
    drain(200);
    check("ack_sticky", 32'(bus.timeout), 1);
    clr_pulse();
    check("clr1_to", 32'(bus.timeout), 0);
    check("clr1_ovr", 32'(bus.overrun_cnt), 0);

    // run timeout: busy stuck high for RUN_TIMEOUT cycles
    conv_mode = 2;
    @(posedge clock); #1;
    bus.speeden = 1'b1;
    bus.speedX  = 16'($urandom);
    bus.speedY  = 16'($urandom);
    @(posedge clock); #1;
    bus.speeden = 1'b0;
    repeat (RUN_TIMEOUT + 3) @(negedge clock);
    check("run_to_before", 32'(bus.timeout), 0);
    @(negedge clock);
    check("run_to_set", 32'(bus.timeout), 1);
    check("run_to_result", {bus.mod, bus.angle}, last_res);
    check("run_to_no_valid", 32'(obs_q.size()), 0);
    conv_mode = 0;
    repeat (3) @(negedge clock);
    conv_lat = 12;
    burst(1, -1);
    drain(200);
    clr_pulse();
    check("clr2_to", 32'(bus.timeout), 0);

    // clear in the same cycle as a drop wins
    conv_lat = 40;
    burst(7, 6);
    @(negedge clock); @(negedge clock);
    check("clr_prio_ovr", 32'(bus.overrun_cnt), 32'(exp_ovr));
    check("clr_prio_level", 32'(bus.fifo_level), FIFO_DEPTH);
    drain(600);

    // enable low: full queue keeps draining, new strobes ignored, no drops
    conv_lat = 40;
    burst(5, -1);
    bus.enable = 1'b0;
    burst(3, -1);
    @(negedge clock); @(negedge clock);
    check("en_level", 32'(bus.fifo_level), FIFO_DEPTH);
    check("en_ovr", 32'(bus.overrun_cnt), 32'(exp_ovr));
    drain(600);
    bus.enable = 1'b1;

    // reset while running with three samples queued
    conv_lat = 60;
    burst(4, -1);
    repeat (8) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    check("rst_no_valid", 32'(obs_q.size()), 0);
    check_zero("rst_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_sched.md
RESULT_SCHED -- requirements
Module: result_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning sample queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter ACK_WAIT, default 8, meaning max cycles from cordic_start to cordic_busy rising.
REQ-003 SHALL have parameter RUN_TIMEOUT, default 255, meaning max cycles cordic_busy may stay high.
REQ-004 SHALL have port clock  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  high: accept new samples; low: ignore speeden.
REQ-007 SHALL have port clr  in  1  synchronous clear of overrun_cnt and timeout.
REQ-008 SHALL have port speeden  in  1  one-cycle strobe: speedX/speedY valid.
REQ-009 SHALL have port speedX  in  16  signed X speed, 10 fractional bits.
REQ-010 SHALL have port speedY  in  16  signed Y speed, 10 fractional bits.
REQ-011 SHALL have port cordic_start  out  1  one-cycle start pulse to the rectangular-to-polar unit.
REQ-012 SHALL have port cordic_x  out  16  X operand, held stable from start until the job ends.
REQ-013 SHALL have port cordic_y  out  16  Y operand, held stable from start until the job ends.
REQ-014 SHALL have port cordic_busy  in  1  converter busy.
REQ-015 SHALL have port cordic_mod  in  16  converter modulus result.
REQ-016 SHALL have port cordic_angle  in  16  converter angle result.
REQ-017 SHALL have port mod  out  16  last captured modulus.
REQ-018 SHALL have port angle  out  16  last captured angle.
REQ-019 SHALL have port valid  out  1  one-cycle pulse when mod/angle are updated.
REQ-020 SHALL have port overrun_cnt  out  16  saturating count of dropped samples.
REQ-021 SHALL have port timeout  out  1  sticky flag for an ack or run timeout.
REQ-022 SHALL have port fifo_level  out  5  current queue occupancy.

Function
REQ-023 SHALL push {speedX,speedY} into the FIFO when speeden&enable and the FIFO is not full.
REQ-024 SHALL drop the sample when the FIFO is full; overrun_cnt SHALL then increment, saturating at 16'hFFFF.
REQ-025 On a simultaneous push and pop with the FIFO full, the push SHALL be accepted and no overrun counted.
REQ-026 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, RUN, CAPTURE.
REQ-027 IDLE->ISSUE when the FIFO is non-empty; the head entry SHALL be popped into cordic_x/cordic_y on that edge.
REQ-028 ISSUE SHALL assert cordic_start for exactly one cycle, then go to WAIT_ACK.
REQ-029 WAIT_ACK->RUN when cordic_busy=1; after ACK_WAIT cycles without busy it SHALL set timeout, discard the job and go to IDLE.
REQ-030 RUN->CAPTURE when cordic_busy=0; after RUN_TIMEOUT cycles of busy it SHALL set timeout and go to IDLE, leaving mod/angle unchanged.
REQ-031 CAPTURE SHALL latch cordic_mod/cordic_angle into mod/angle, pulse valid for one cycle, then go to IDLE.
REQ-032 Latency from push into an empty FIFO with the converter idle to cordic_start SHALL be 2 cycles.
REQ-033 Deasserting enable SHALL NOT flush the FIFO or abort an in-flight job; queued samples SHALL drain normally.
REQ-034 Clearing by clr SHALL take priority over an overrun increment or timeout set in the same cycle.
REQ-035 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-036 On reset_n=0 the block SHALL asynchronously enter IDLE and set FIFO empty, cordic_start=0, cordic_x=cordic_y=0, mod=angle=0, valid=0, overrun_cnt=0, timeout=0, fifo_level=0.
REQ-037 A reset during RUN SHALL abandon the job with no valid pulse; a busy high on reset release SHALL NOT start a new job until the FIFO is non-empty.

Verification
REQ-038 Single sample: speeden with X=16'h0400, Y=0 and a model converter busy for 20 cycles -> cordic_start 2 cycles later, one valid, mod/angle equal to the model outputs.
REQ-039 Burst: 6 speedens back-to-back with the converter busy for 40 cycles, FIFO_DEPTH=4 -> 4 queued plus 1 in flight, overrun_cnt=1, 5 valid pulses in order.
REQ-040 Ack timeout: converter never asserts busy -> timeout=1 after 8 cycles in WAIT_ACK, no valid, next sample still processed.
REQ-041 Run timeout: busy stuck high -> timeout=1 after 255 cycles, FSM in IDLE, mod unchanged; clr -> timeout=0, overrun_cnt=0.
REQ-042 Reset mid-job: reset_n low during RUN with 3 entries queued -> all outputs 0, fifo_level=0, no valid after release.
REQ-043 enable=0 with 2 entries queued: further speedens are ignored, 2 valid pulses occur, overrun_cnt unchanged.
